router_sync_ctrl: RTL and testbench

- Synchroniser and control block between the router FSM and its three output FIFOs.
- Captures the 2-bit destination address when the FSM detects a header.
- Steers the FSM write strobe to the selected FIFO and returns that FIFO's full flag.
- Drives a per-port valid-out, and issues a per-port soft reset when a valid FIFO is not read within a timeout window.

---
 rtl/router_pkg.sv | 28 ++
 rtl/router_timeout_cnt.sv | 35 +++
 rtl/router_sync_ctrl.sv | 102 ++++++++++
 tb/tb_router_sync_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router synchroniser: address encodings, port count
// and the default stall timeout.
package router_pkg;

    typedef enum logic [1:0] {
        PORT0    = 2'b00,
        PORT1    = 2'b01,
        PORT2    = 2'b10,
        ADDR_INV = 2'b11
    } addr_t;

    localparam int NUM_PORTS       = 3;
    localparam int DEFAULT_TIMEOUT = 30;

    // One-hot FIFO select for a destination address; the invalid address selects nothing.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input addr_t addr);
        logic [NUM_PORTS-1:0] sel;
        sel = '0;
        case (addr)
            PORT0:   sel = 3'b001;
            PORT1:   sel = 3'b010;
            PORT2:   sel = 3'b100;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/router_timeout_cnt.sv
// Per-port stall watchdog: pulses soft_rst for one cycle after TIMEOUT consecutive
// cycles in which the FIFO holds data and is not read.
module router_timeout_cnt #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic rd,
    output logic soft_rst
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // A single read or empty cycle restarts the window, and also suppresses an expiring pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            soft_rst <= 1'b0;
        end else if (!vld || rd) begin
            cnt      <= '0;
            soft_rst <= 1'b0;
        end else if (cnt == LAST) begin
            cnt      <= '0;
            soft_rst <= 1'b1;
        end else begin
            cnt      <= cnt + CNT_W'(1);
            soft_rst <= 1'b0;
        end
    end

endmodule

// File: rtl/router_sync_ctrl.sv
// Router synchroniser: latches the packet address, steers writes to one of three FIFOs,
// and runs a stall watchdog per FIFO. Optional addr_err output under ROUTER_SYNC_ADDR_ERR_EN.
module router_sync_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       detect_add,
    input  logic       write_enb_reg,
    input  logic [1:0] din,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    output logic [2:0] wr_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_rst_0,
    output logic       soft_rst_1,
    output logic       soft_rst_2
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    ,
    output logic       addr_err
`endif
);

    addr_t                addr;
    logic [NUM_PORTS-1:0] vld;
    logic [NUM_PORTS-1:0] rd;
    logic [NUM_PORTS-1:0] soft_rst;

    // A write in the detect_add cycle still goes to the previously latched port.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= PORT0;
        end else if (detect_add) begin
            addr <= addr_t'(din);
        end
    end

`ifdef ROUTER_SYNC_ADDR_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if (detect_add) begin
            addr_err <= (din == ADDR_INV);
        end
    end
`endif

    always_comb begin
        wr_enb = '0;
        if (write_enb_reg) begin
            wr_enb = port_onehot(addr);
        end
    end

    always_comb begin
        fifo_full = 1'b0;
        case (addr)
            PORT0:   fifo_full = full_0;
            PORT1:   fifo_full = full_1;
            PORT2:   fifo_full = full_2;
            default: fifo_full = 1'b0;
        endcase
    end

    assign vld = {~empty_2, ~empty_1, ~empty_0};
    assign rd  = {read_enb_2, read_enb_1, read_enb_0};

    assign vld_out_0 = vld[0];
    assign vld_out_1 = vld[1];
    assign vld_out_2 = vld[2];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_tmo
        router_timeout_cnt #(
            .TIMEOUT(TIMEOUT),
            .CNT_W  (CNT_W)
        ) u_tmo (
            .clk     (clk),
            .rst     (rst),
            .vld     (vld[p]),
            .rd      (rd[p]),
            .soft_rst(soft_rst[p])
        );
    end

    assign soft_rst_0 = soft_rst[0];
    assign soft_rst_1 = soft_rst[1];
    assign soft_rst_2 = soft_rst[2];

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Bench for router_sync_ctrl: directed scenarios plus random traffic against a
// stall-run-length reference model.
module tb_router_sync_ctrl;

    localparam int TMO = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       detect_add;
    logic       write_enb_reg;
    logic [1:0] din;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] rd;
    logic [2:0] wr_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_rst_0, soft_rst_1, soft_rst_2;
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    logic       addr_err;
`endif

    int         errors = 0;
    int         checks = 0;

    // Reference model state: latched address, length of the current stall run per port.
    logic [1:0] m_addr;
    logic       m_err;
    int         run [3];
    logic [2:0] exp_soft;
    int         pulses;

    always #5 clk = ~clk;

    router_sync_ctrl #(.TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .detect_add   (detect_add),
        .write_enb_reg(write_enb_reg),
        .din          (din),
        .full_0       (full[0]),
        .full_1       (full[1]),
        .full_2       (full[2]),
        .empty_0      (empty[0]),
        .empty_1      (empty[1]),
        .empty_2      (empty[2]),
        .read_enb_0   (rd[0]),
        .read_enb_1   (rd[1]),
        .read_enb_2   (rd[2]),
        .wr_enb       (wr_enb),
        .fifo_full    (fifo_full),
        .vld_out_0    (vld_out_0),
        .vld_out_1    (vld_out_1),
        .vld_out_2    (vld_out_2),
        .soft_rst_0   (soft_rst_0),
        .soft_rst_1   (soft_rst_1),
        .soft_rst_2   (soft_rst_2)
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        ,
        .addr_err     (addr_err)
`endif
    );

    task automatic check_outputs();
        logic [2:0] exp_wr;
        logic       exp_full;
        exp_wr   = (write_enb_reg && m_addr != 2'b11) ? (3'b001 << m_addr) : 3'b000;
        exp_full = (m_addr != 2'b11) ? full[m_addr] : 1'b0;
        checks++;
        assert (wr_enb === exp_wr) else begin
            errors++;
            $error("FAIL wr_enb got=%b exp=%b at %0t", wr_enb, exp_wr, $time);
        end
        checks++;
        assert (fifo_full === exp_full) else begin
            errors++;
            $error("FAIL fifo_full got=%b exp=%b at %0t", fifo_full, exp_full, $time);
        end
        checks++;
        assert ({vld_out_2, vld_out_1, vld_out_0} === ~empty) else begin
            errors++;
            $error("FAIL vld_out got=%b exp=%b at %0t", {vld_out_2, vld_out_1, vld_out_0}, ~empty, $time);
        end
        checks++;
        assert ({soft_rst_2, soft_rst_1, soft_rst_0} === exp_soft) else begin
            errors++;
            $error("FAIL soft_rst got=%b exp=%b at %0t", {soft_rst_2, soft_rst_1, soft_rst_0}, exp_soft, $time);
        end
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        checks++;
        assert (addr_err === m_err) else begin
            errors++;
            $error("FAIL addr_err got=%b exp=%b at %0t", addr_err, m_err, $time);
        end
`endif
    endtask

    // One rising edge: update the model from the inputs the DUT sampled, then check.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_addr   = 2'b00;
            m_err    = 1'b0;
            exp_soft = 3'b000;
            for (int p = 0; p < 3; p++) run[p] = 0;
        end else begin
            if (detect_add) begin
                m_addr = din;
                m_err  = (din == 2'b11);
            end
            for (int p = 0; p < 3; p++) begin
                if (!empty[p] && !rd[p]) begin
                    run[p]++;
                    exp_soft[p] = (run[p] % TMO == 0);
                end else begin
                    run[p]      = 0;
                    exp_soft[p] = 1'b0;
                end
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        rst           = 1'b1;
        detect_add    = 1'b0;
        write_enb_reg = 1'b0;
        din           = 2'b00;
        full          = 3'b000;
        empty         = 3'b111;
        rd            = 3'b000;
        m_addr        = 2'b00;
        m_err         = 1'b0;
        exp_soft      = 3'b000;
        for (int p = 0; p < 3; p++) run[p] = 0;

        // Reset state, then write strobe with reset address goes to FIFO 0.
        step();
        step();
        write_enb_reg = 1'b1;
        step();
        rst = 1'b0;

        // Capture port 2 and check the full flag routing both ways.
        detect_add = 1'b1;
        din        = 2'b10;
        step();
        detect_add = 1'b0;
        full       = 3'b100;
        step();
        full       = 3'b011;
        step();

        // Address sweep with and without the write strobe.
        for (int w = 1; w >= 0; w--) begin
            for (int a = 0; a < 4; a++) begin
                if (a == 2) continue;
                write_enb_reg = w[0];
                detect_add    = 1'b1;
                din           = a[1:0];
                full          = 3'($urandom_range(0, 7));
                step();
                detect_add = 1'b0;
                step();
            end
        end

        // Continuous stall on port 2: pulse every TMO cycles, exactly two in 65 edges.
        write_enb_reg = 1'b0;
        empty  = 3'b011;
        pulses = 0;
        for (int i = 0; i < 65; i++) begin
            step();
            if (soft_rst_2) pulses++;
        end
        checks++;
        assert (pulses === 2) else begin
            errors++;
            $error("FAIL stall_pulse_count got=%0d exp=%0d", pulses, 2);
        end
        empty = 3'b111;
        step();

        // Read at stalled cycle 20 restarts the window.
        empty = 3'b011;
        for (int i = 0; i < 19; i++) step();
        rd = 3'b100;
        step();
        rd = 3'b000;
        for (int i = 0; i < 32; i++) step();

        // Read held: never a pulse.
        rd     = 3'b100;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (soft_rst_2) pulses++;
        end
        checks++;
        assert (pulses === 0) else begin
            errors++;
            $error("FAIL held_read_pulse got=%0d exp=%0d", pulses, 0);
        end
        rd    = 3'b000;
        empty = 3'b111;
        step();

        // Reset mid-stall on port 0, after moving the address away from port 0.
        detect_add = 1'b1;
        din        = 2'b01;
        empty      = 3'b110;
        step();
        detect_add = 1'b0;
        for (int i = 0; i < 14; i++) step();
        rst = 1'b1;
        step();
        rst           = 1'b0;
        write_enb_reg = 1'b1;
        for (int i = 0; i < 32; i++) step();
        empty = 3'b111;
        step();

        // Invalid then valid address capture.
        detect_add = 1'b1;
        din        = 2'b11;
        step();
        detect_add = 1'b0;
        step();
        detect_add = 1'b1;
        din        = 2'b01;
        step();
        detect_add = 1'b0;
        step();

        // Random traffic, biased so that long stalls occur.
        for (int i = 0; i < 1500; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            detect_add    = ($urandom_range(0, 7) == 0);
            din           = 2'($urandom_range(0, 3));
            write_enb_reg = 1'($urandom_range(0, 1));
            full          = 3'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) begin
                empty[p] = ($urandom_range(0, 31) == 0);
                rd[p]    = ($urandom_range(0, 63) == 0);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
